elevator_car_ctrl: RTL and testbench

- Sequential successor to the combinational one-step floor incrementer/decrementer.
- Holds the car's floor position and latches pending floor requests in a bitmap.
- Chooses the travel direction using SCAN: keep going while requests remain ahead, otherwise reverse.
- Steps one floor per travel interval with saturation at the end floors, and runs a timed door-open phase at each served floor.
- Sits between the request/button logic and the floor display / door actuator.

---
 rtl/elevator_car_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_elevator_car_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: single-car controller with SCAN scheduling.
// Holds the car floor, latches floor requests in a bitmap, steps one floor every
// TRAVEL_CYCLES cycles toward pending requests and opens the door for DOOR_CYCLES
// cycles at every served floor.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   req_valid  request strobe, at most one request per cycle
//   req_floor  requested floor, sampled when req_valid=1
//   req_err    one-cycle pulse after a request with req_floor >= NUM_FLOORS
//   floor      current car floor
//   dir_up     travel direction (1 = up), retained outside MOVE
//   moving     high while in MOVE
//   door_open  high while in DOOR
//   arrived    one-cycle pulse on the first DOOR cycle after a MOVE stop
//   pending    request bitmap, bit i = floor i requested
module elevator_car_ctrl #(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_err,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned MaxCycles = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES
                                                                    : DOOR_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [TimerW-1:0]  TravelLoad = TimerW'(TRAVEL_CYCLES - 1);
  localparam logic [TimerW-1:0]  DoorLoad   = TimerW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TopFloor   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W:0]   NumFloorsW = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic                    dir_up_q, dir_up_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    arrived_q, arrived_d;
  logic                    req_err_q, req_err_d;
  logic                    moving_q, door_open_q;

  logic                    req_ok;
  logic [NUM_FLOORS-1:0]   set_mask, clr_mask;
  logic [FLOOR_W-1:0]      next_floor;
  logic                    at_end;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (p[i] && (i > int'(f))) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0]    f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (p[i] && (i < int'(f))) r = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    timer_d    = timer_q;
    arrived_d  = 1'b0;
    clr_mask   = '0;
    req_ok     = req_valid && ({1'b0, req_floor} < NumFloorsW);
    req_err_d  = req_valid && !req_ok;
    set_mask   = req_ok ? (NUM_FLOORS'(1) << req_floor) : '0;
    next_floor = dir_up_q ? (floor_q + 1'b1) : (floor_q - 1'b1);
    at_end     = dir_up_q ? (floor_q == TopFloor) : (floor_q == '0);

    unique case (state_q)
      StIdle: begin
        if (pending_q[floor_q]) begin
          clr_mask[floor_q] = 1'b1;
          state_d           = StDoor;
          timer_d           = DoorLoad;
        end else if (any_above(pending_q, floor_q) &&
                     (dir_up_q || !any_below(pending_q, floor_q))) begin
          dir_up_d = 1'b1;
          state_d  = StMove;
          timer_d  = TravelLoad;
        end else if (any_below(pending_q, floor_q)) begin
          dir_up_d = 1'b0;
          state_d  = StMove;
          timer_d  = TravelLoad;
        end
      end
      StMove: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (at_end) begin
          // Step would leave the shaft: hold position and re-plan from IDLE.
          state_d = StIdle;
        end else begin
          floor_d = next_floor;
          if (pending_q[next_floor]) begin
            clr_mask[next_floor] = 1'b1;
            arrived_d            = 1'b1;
            state_d              = StDoor;
            timer_d              = DoorLoad;
          end else if (dir_up_q ? any_above(pending_q, next_floor)
                                : any_below(pending_q, next_floor)) begin
            timer_d = TravelLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDoor: begin
        if (req_ok && (req_floor == floor_q)) begin
          // Call for the open floor keeps the door open instead of queueing.
          set_mask = '0;
          timer_d  = DoorLoad;
        end else if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear after set: a stop serving a floor wins over a same-edge request for it.
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      floor_q     <= '0;
      dir_up_q    <= 1'b1;
      timer_q     <= '0;
      pending_q   <= '0;
      arrived_q   <= 1'b0;
      req_err_q   <= 1'b0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_up_q    <= dir_up_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      arrived_q   <= arrived_d;
      req_err_q   <= req_err_d;
      moving_q    <= (state_d == StMove);
      door_open_q <= (state_d == StDoor);
    end
  end

  assign req_err   = req_err_q;
  assign floor     = floor_q;
  assign dir_up    = dir_up_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;
  assign arrived   = arrived_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl: an 8-floor instance for trip, door,
// SCAN and reset scenarios, and a 6-floor instance for range error and top floor.
module tb_elevator_car_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-floor instance
  logic       rst8, rv8;
  logic [2:0] rf8;
  logic       err8, dir8, mov8, door8, arr8;
  logic [2:0] fl8;
  logic [7:0] pend8;

  // 6-floor instance
  logic       rst6, rv6;
  logic [2:0] rf6;
  logic       err6, dir6, mov6, door6, arr6;
  logic [2:0] fl6;
  logic [5:0] pend6;

  elevator_car_ctrl #(
    .NUM_FLOORS   (8),
    .FLOOR_W      (3),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) u_dut8 (
    .clk      (clk),
    .reset    (rst8),
    .req_valid(rv8),
    .req_floor(rf8),
    .req_err  (err8),
    .floor    (fl8),
    .dir_up   (dir8),
    .moving   (mov8),
    .door_open(door8),
    .arrived  (arr8),
    .pending  (pend8)
  );

  elevator_car_ctrl #(
    .NUM_FLOORS   (6),
    .FLOOR_W      (3),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) u_dut6 (
    .clk      (clk),
    .reset    (rst6),
    .req_valid(rv6),
    .req_floor(rf6),
    .req_err  (err6),
    .floor    (fl6),
    .dir_up   (dir6),
    .moving   (mov6),
    .door_open(door6),
    .arrived  (arr6),
    .pending  (pend6)
  );

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int d_cnt, m_cnt, n_arr, cyc, max_fl;
    int arr_fl[4];
    int arr_cy[4];
    int arr_dir[4];

    rst8 = 1'b1; rv8 = 1'b0; rf8 = '0;
    rst6 = 1'b1; rv6 = 1'b0; rf6 = '0;
    repeat (2) step();
    rst8 = 1'b0;
    rst6 = 1'b0;

    // Reset state
    chk("rst_floor", 32'(fl8), 32'd0);
    chk("rst_dir", 32'(dir8), 32'd1);
    chk("rst_pending", 32'(pend8), 32'd0);
    chk("rst_door", 32'(door8), 32'd0);
    chk("rst_moving", 32'(mov8), 32'd0);
    chk("rst_req_err", 32'(err8), 32'd0);
    chk("rst_arrived", 32'(arr8), 32'd0);
    chk("rst6_pending", 32'(pend6), 32'd0);
    step();
    chk("idle_after_rst_moving", 32'(mov8), 32'd0);

    // Basic trip 0 -> 3
    rv8 = 1'b1; rf8 = 3'd3;
    step(); rv8 = 1'b0;                       // cycle 1
    chk("trip_pending_c1", 32'(pend8), 32'h08);
    chk("trip_moving_c1", 32'(mov8), 32'd0);
    step();                                   // cycle 2
    chk("trip_moving_c2", 32'(mov8), 32'd1);
    chk("trip_floor_c2", 32'(fl8), 32'd0);
    repeat (4) step();                        // cycle 6
    chk("trip_floor_c6", 32'(fl8), 32'd1);
    repeat (4) step();                        // cycle 10
    chk("trip_floor_c10", 32'(fl8), 32'd2);
    repeat (3) step();                        // cycle 13
    chk("trip_arrived_c13", 32'(arr8), 32'd0);
    step();                                   // cycle 14
    chk("trip_floor_c14", 32'(fl8), 32'd3);
    chk("trip_arrived_c14", 32'(arr8), 32'd1);
    chk("trip_door_c14", 32'(door8), 32'd1);
    chk("trip_moving_c14", 32'(mov8), 32'd0);
    chk("trip_pending_c14", 32'(pend8), 32'd0);
    step();                                   // cycle 15
    chk("trip_arrived_c15", 32'(arr8), 32'd0);
    chk("trip_door_c15", 32'(door8), 32'd1);
    step();                                   // cycle 16
    chk("trip_door_c16", 32'(door8), 32'd1);
    step();                                   // cycle 17
    chk("trip_door_c17", 32'(door8), 32'd0);
    chk("trip_moving_c17", 32'(mov8), 32'd0);

    // Same-floor request at floor 0
    rst8 = 1'b1; step(); rst8 = 1'b0;
    chk("same_rst_floor", 32'(fl8), 32'd0);
    rv8 = 1'b1; rf8 = 3'd0;
    step(); rv8 = 1'b0;
    chk("same_pending", 32'(pend8), 32'h01);
    d_cnt = 0; m_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      d_cnt += int'(door8);
      m_cnt += int'(mov8);
    end
    chk("same_door_cycles", 32'(d_cnt), 32'd3);
    chk("same_never_moving", 32'(m_cnt), 32'd0);
    chk("same_floor", 32'(fl8), 32'd0);
    chk("same_pending_clr", 32'(pend8), 32'd0);

    // Door reload by a second same-floor call
    rv8 = 1'b1; rf8 = 3'd0;
    step(); rv8 = 1'b0;                       // cycle 1
    step();                                   // cycle 2
    chk("reload_door_c2", 32'(door8), 32'd1);
    step();                                   // cycle 3
    rv8 = 1'b1; rf8 = 3'd0;
    step(); rv8 = 1'b0;                       // cycle 4
    chk("reload_pending", 32'(pend8), 32'd0);
    d_cnt = 0; m_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      d_cnt += int'(door8);
      m_cnt += int'(mov8);
      step();
    end
    chk("reload_door_cycles", 32'(d_cnt), 32'd3);
    chk("reload_never_moving", 32'(m_cnt), 32'd0);

    // SCAN order: heading to 5, at floor 2 add 1 (behind) and 4 (ahead)
    rst8 = 1'b1; step(); rst8 = 1'b0;
    rv8 = 1'b1; rf8 = 3'd5;
    step(); rv8 = 1'b0;                       // cycle 1
    repeat (9) step();                        // cycle 10
    chk("scan_floor_c10", 32'(fl8), 32'd2);
    chk("scan_moving_c10", 32'(mov8), 32'd1);
    chk("scan_dir_c10", 32'(dir8), 32'd1);
    rv8 = 1'b1; rf8 = 3'd1;
    step();                                   // cycle 11
    rf8 = 3'd4;
    step(); rv8 = 1'b0;                       // cycle 12
    chk("scan_pending_c12", 32'(pend8), 32'h32);
    n_arr = 0;
    for (int i = 0; i < 4; i++) begin
      arr_fl[i] = -1; arr_cy[i] = -1; arr_dir[i] = -1;
    end
    for (cyc = 12; cyc < 70; cyc++) begin
      if (arr8) begin
        if (n_arr < 4) begin
          arr_fl[n_arr]  = int'(fl8);
          arr_cy[n_arr]  = cyc;
          arr_dir[n_arr] = int'(dir8);
        end
        n_arr++;
      end
      step();
    end
    chk("scan_arrivals", 32'(n_arr), 32'd3);
    chk("scan_stop1_floor", 32'(arr_fl[0]), 32'd4);
    chk("scan_stop1_cycle", 32'(arr_cy[0]), 32'd18);
    chk("scan_stop1_dir", 32'(arr_dir[0]), 32'd1);
    chk("scan_stop2_floor", 32'(arr_fl[1]), 32'd5);
    chk("scan_stop2_cycle", 32'(arr_cy[1]), 32'd26);
    chk("scan_stop3_floor", 32'(arr_fl[2]), 32'd1);
    chk("scan_stop3_cycle", 32'(arr_cy[2]), 32'd46);
    chk("scan_stop3_dir", 32'(arr_dir[2]), 32'd0);
    chk("scan_pending_end", 32'(pend8), 32'd0);
    chk("scan_idle_end", 32'({mov8, door8}), 32'd0);

    // Range error on the 6-floor instance
    rv6 = 1'b1; rf6 = 3'd7;
    step(); rv6 = 1'b0;
    chk("err7_pulse", 32'(err6), 32'd1);
    chk("err7_pending", 32'(pend6), 32'd0);
    step();
    chk("err7_pulse_end", 32'(err6), 32'd0);
    rv6 = 1'b1; rf6 = 3'd6;
    step(); rv6 = 1'b0;
    chk("err6_pulse", 32'(err6), 32'd1);
    chk("err6_pending", 32'(pend6), 32'd0);
    step();

    // Top-floor trip 0 -> 5 on the 6-floor instance
    rv6 = 1'b1; rf6 = 3'd5;
    step(); rv6 = 1'b0;                       // cycle 1
    chk("top_pending", 32'(pend6), 32'h20);
    chk("top_no_err", 32'(err6), 32'd0);
    n_arr = 0; max_fl = 0; arr_cy[0] = -1;
    for (cyc = 1; cyc < 40; cyc++) begin
      if (int'(fl6) > max_fl) max_fl = int'(fl6);
      if (arr6) begin
        if (n_arr == 0) arr_cy[0] = cyc;
        n_arr++;
      end
      step();
    end
    chk("top_arrivals", 32'(n_arr), 32'd1);
    chk("top_arrive_cycle", 32'(arr_cy[0]), 32'd22);
    chk("top_max_floor", 32'(max_fl), 32'd5);
    chk("top_final_floor", 32'(fl6), 32'd5);
    chk("top_final_moving", 32'(mov6), 32'd0);

    // Reset mid-move: travel 1 -> 4 with {4,6} pending
    rst8 = 1'b1; step(); rst8 = 1'b0;
    rv8 = 1'b1; rf8 = 3'd1;
    step(); rv8 = 1'b0;
    repeat (8) step();                        // cycle 9: idle at floor 1
    chk("mid_at_floor1", 32'(fl8), 32'd1);
    chk("mid_idle", 32'({mov8, door8}), 32'd0);
    rv8 = 1'b1; rf8 = 3'd4;
    step();                                   // cycle 1
    rf8 = 3'd6;
    step(); rv8 = 1'b0;                       // cycle 2
    chk("mid_moving_c2", 32'(mov8), 32'd1);
    step(); step();                           // cycle 4
    chk("mid_pending_c4", 32'(pend8), 32'h50);
    chk("mid_floor_c4", 32'(fl8), 32'd1);
    rst8 = 1'b1;
    step(); rst8 = 1'b0;                      // cycle 5
    chk("mid_rst_floor", 32'(fl8), 32'd0);
    chk("mid_rst_pending", 32'(pend8), 32'd0);
    chk("mid_rst_moving", 32'(mov8), 32'd0);
    chk("mid_rst_arrived", 32'(arr8), 32'd0);
    chk("mid_rst_dir", 32'(dir8), 32'd1);
    n_arr = 0; m_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_arr += int'(arr8);
      m_cnt += int'(mov8);
    end
    chk("mid_no_arrival", 32'(n_arr), 32'd0);
    chk("mid_no_motion", 32'(m_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
